// File: rtl/adc_acq_ctrl_if.sv
// adc_acq_ctrl_if: control, ADC pin and sample-stream signals of the ADC
// acquisition controller. The slave side is the controller itself; the master
// side is whatever drives start/abort and the ADC data bus.
interface adc_acq_ctrl_if #(
    parameter int ADC_W = 8,
    parameter int IDX_W = 11
);
    logic             start;
    logic             abort;
    logic [ADC_W-1:0] adc_data;
    logic             adc_clk;
    logic             adc_oe_n;
    logic             busy;
    logic [ADC_W-1:0] smp_data;
    logic [IDX_W-1:0] smp_idx;
    logic             smp_valid;
    logic             line_done;

    modport master (
        output start, abort, adc_data,
        input  adc_clk, adc_oe_n, busy, smp_data, smp_idx, smp_valid, line_done
    );

    modport slave (
        input  start, abort, adc_data,
        output adc_clk, adc_oe_n, busy, smp_data, smp_idx, smp_valid, line_done
    );
endinterface

// File: rtl/adc_acq_ctrl.sv
// adc_acq_ctrl: divides clk down to the ADC conversion clock, drives the ADC
// output enable, discards PIPE_LAT pipeline captures after start and then
// streams SAMPLES indexed samples with a one-cycle valid strobe each.
// Optional build macro ADC_TEST_PATTERN_EN: captured data is replaced by the
// low ADC_W bits of the sample index (ramp); timing is unchanged.
module adc_acq_ctrl #(
    parameter int CLK_DIV  = 10,
    parameter int ADC_W    = 8,
    parameter int SAMPLES  = 1024,
    parameter int PIPE_LAT = 3,
    parameter int IDX_W    = 11
) (
    input  logic          clk,
    input  logic          rst,
    adc_acq_ctrl_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FL_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, FLUSH, ACQ, DONE} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [IDX_W-1:0] smp_cnt_q, smp_cnt_d;
    logic             adc_clk_q, adc_clk_d;
    logic             adc_oe_n_q, adc_oe_n_d;
    logic             busy_q, busy_d;
    logic [ADC_W-1:0] smp_data_q, smp_data_d;
    logic [IDX_W-1:0] smp_idx_q, smp_idx_d;
    logic             smp_valid_q, smp_valid_d;
    logic             line_done_q, line_done_d;
    logic             cap_edge;
    logic [ADC_W-1:0] cap_data;

    // Source of the captured value: real ADC bus or the index ramp.
`ifdef ADC_TEST_PATTERN_EN
    logic [ADC_W+IDX_W-1:0] idx_ext;
    assign idx_ext  = {{ADC_W{1'b0}}, smp_cnt_q};
    assign cap_data = idx_ext[ADC_W-1:0];
`else
    assign cap_data = bus.adc_data;
`endif

    // Free-running divider, sequencer next state and registered output values.
    always_comb begin
        cap_edge    = (div_cnt_q == DIV_LAST);
        div_cnt_d   = cap_edge ? '0 : div_cnt_q + 1'b1;
        adc_clk_d   = (div_cnt_q >= DIV_HALF);
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        smp_data_d  = smp_data_q;
        smp_idx_d   = smp_idx_q;
        smp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    flush_cnt_d = '0;
                    smp_cnt_d   = '0;
                    state_d     = (PIPE_LAT == 0) ? ACQ : FLUSH;
                end
            end
            FLUSH: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cap_edge) begin
                    if (flush_cnt_q == FL_LAST) begin
                        smp_cnt_d = '0;
                        state_d   = ACQ;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
            end
            ACQ: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (smp_valid_q && smp_idx_q == IDX_LAST) begin
                    // Final strobe is on the bus this cycle; end-of-line follows it.
                    state_d = DONE;
                end else if (cap_edge) begin
                    smp_data_d  = cap_data;
                    smp_idx_d   = smp_cnt_q;
                    smp_valid_d = 1'b1;
                    if (smp_cnt_q != IDX_LAST) begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered so they line up with the state they describe.
        line_done_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        adc_oe_n_d  = (state_d == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            flush_cnt_q <= '0;
            smp_cnt_q   <= '0;
            adc_clk_q   <= 1'b0;
            adc_oe_n_q  <= 1'b1;
            busy_q      <= 1'b0;
            smp_data_q  <= '0;
            smp_idx_q   <= '0;
            smp_valid_q <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            adc_clk_q   <= adc_clk_d;
            adc_oe_n_q  <= adc_oe_n_d;
            busy_q      <= busy_d;
            smp_data_q  <= smp_data_d;
            smp_idx_q   <= smp_idx_d;
            smp_valid_q <= smp_valid_d;
            line_done_q <= line_done_d;
        end
    end

    assign bus.adc_clk   = adc_clk_q;
    assign bus.adc_oe_n  = adc_oe_n_q;
    assign bus.busy      = busy_q;
    assign bus.smp_data  = smp_data_q;
    assign bus.smp_idx   = smp_idx_q;
    assign bus.smp_valid = smp_valid_q;
    assign bus.line_done = line_done_q;
endmodule
